// File: rtl/bus_source_decoder.sv
// bus_source_decoder: registered binary-to-one-hot decoder for the bus-source
// out-enables. It accepts source codes over a valid/ready handshake, flags
// out-of-range codes, and inserts break-before-make idle cycles between two
// different sources so that two drivers never overlap on the bus.
// `release` is a reserved word, so the release input is named release_req.
module bus_source_decoder #(
   parameter int unsigned NUM_OUT    = 32,
   parameter int unsigned SEL_W      = 5,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic               clock,
   input  logic               clear_n,
   input  logic               req_valid,
   input  logic [SEL_W-1:0]   req_code,
   output logic               req_ready,
   input  logic               release_req,
   output logic [NUM_OUT-1:0] out_en,
   output logic [SEL_W-1:0]   cur_code,
   output logic               busy,
   output logic               err_invalid
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GAP   = 2'd1,
      DRIVE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   cur_code_q, cur_code_d;
   logic [SEL_W-1:0]   pend_code_q, pend_code_d;
   logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic               err_q, err_d;
   logic [NUM_OUT-1:0] out_en_q, out_en_d;
   logic               code_ok;
   logic               accept;

   // Range check: the requested code addresses an existing out-enable line.
   always_comb begin
      code_ok = 1'b0;
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
         if (req_code == SEL_W'(i)) code_ok = 1'b1;
      end
   end

   // State register and all registered outputs; reset forces the bus undriven.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q     <= IDLE;
         cur_code_q  <= '0;
         pend_code_q <= '0;
         gap_cnt_q   <= '0;
         err_q       <= 1'b0;
         out_en_q    <= '0;
      end else begin
         state_q     <= state_d;
         cur_code_q  <= cur_code_d;
         pend_code_q <= pend_code_d;
         gap_cnt_q   <= gap_cnt_d;
         err_q       <= err_d;
         out_en_q    <= out_en_d;
      end
   end

   // Next-state logic; out_en is decoded from the next state so it is glitch-free.
   // The gap counter is loaded with GAP_CYCLES-1 so GAP lasts exactly GAP_CYCLES.
   always_comb begin
      state_d     = state_q;
      cur_code_d  = cur_code_q;
      pend_code_d = pend_code_q;
      gap_cnt_d   = gap_cnt_q;
      err_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (!code_ok) begin
                  err_d = 1'b1;
               end else begin
                  state_d    = DRIVE;
                  cur_code_d = req_code;
               end
            end
         end
         DRIVE: begin
            if (release_req) begin
               state_d = IDLE;
            end else if (accept) begin
               if (!code_ok) begin
                  err_d = 1'b1;
               end else if (req_code != cur_code_q) begin
                  if (GAP_CYCLES == 0) begin
                     cur_code_d = req_code;
                  end else begin
                     state_d     = GAP;
                     pend_code_d = req_code;
                     gap_cnt_d   = CNT_W'(GAP_CYCLES - 1);
                  end
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) begin
               state_d    = DRIVE;
               cur_code_d = pend_code_q;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      out_en_d = '0;
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
         out_en_d[i] = (state_d == DRIVE) && (cur_code_d == SEL_W'(i));
      end
   end

   // Outputs: handshake readiness (release wins over a concurrent request) and status.
   always_comb begin
      req_ready   = (state_q == IDLE) || ((state_q == DRIVE) && !release_req);
      accept      = req_valid && req_ready;
      busy        = (state_q != IDLE);
      out_en      = out_en_q;
      cur_code    = cur_code_q;
      err_invalid = err_q;
   end

endmodule
